// File: rtl/imm_ext_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imm_ext_pkg
//  Description : Shared widths, extension-mode encodings and skid-buffer
//                state type for the registered immediate-extension stage.
//  Revision    : 1.0  initial release
// ============================================================================
package imm_ext_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_IMM_W  = 16;
  localparam int DEF_J_W    = 26;
  localparam int MODE_W     = 3;

  // Extension mode encodings; anything above EXT_JMP is illegal.
  localparam logic [MODE_W-1:0] EXT_ZERO = 3'd0;
  localparam logic [MODE_W-1:0] EXT_SIGN = 3'd1;
  localparam logic [MODE_W-1:0] EXT_LUI  = 3'd2;
  localparam logic [MODE_W-1:0] EXT_BR   = 3'd3;
  localparam logic [MODE_W-1:0] EXT_JMP  = 3'd4;

  // Occupancy of the two-entry skid buffer.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_e;

endpackage
`default_nettype wire

// File: rtl/imm_ext_core.sv
`default_nettype none
// ============================================================================
//  Module      : imm_ext_core
//  Description : Combinational mode arithmetic: zero/sign extension, LUI
//                placement, branch target and jump target formation.
//  Revision    : 1.0  initial release
// ============================================================================
module imm_ext_core #(
  parameter int DATA_W = imm_ext_pkg::DEF_DATA_W,
  parameter int IMM_W  = imm_ext_pkg::DEF_IMM_W,
  parameter int J_W    = imm_ext_pkg::DEF_J_W,
  parameter int MODE_W = imm_ext_pkg::MODE_W
) (
  input  logic [J_W-1:0]    idx,
  input  logic [DATA_W-1:0] pc_plus4,
  input  logic [MODE_W-1:0] mode,
  output logic [DATA_W-1:0] data,
  output logic              err
);
  import imm_ext_pkg::*;

  // Bits of the jump target supplied by the index field (index plus word offset).
  localparam int c_LOW_W = J_W + 2;

  logic [IMM_W-1:0]  w_imm;
  logic [DATA_W-1:0] w_zext;
  logic [DATA_W-1:0] w_sext;
  logic [DATA_W-1:0] w_lui;
  logic [DATA_W-1:0] w_br;
  logic [DATA_W-1:0] w_jmp;

  assign w_imm  = idx[IMM_W-1:0];
  assign w_zext = {{(DATA_W-IMM_W){1'b0}}, w_imm};
  assign w_sext = {{(DATA_W-IMM_W){w_imm[IMM_W-1]}}, w_imm};
  assign w_lui  = {w_imm, {(DATA_W-IMM_W){1'b0}}};
  // Branch target wraps modulo 2^DATA_W; carries out of the top are dropped.
  assign w_br   = pc_plus4 + (w_sext << 2);
  // Keep the PC region bits above the index field, replace the rest.
  assign w_jmp  = ((pc_plus4 >> c_LOW_W) << c_LOW_W) | DATA_W'({idx, 2'b00});

  // Select the operand for the requested mode; illegal modes yield zero with err.
  always_comb begin
    data = '0;
    err  = 1'b0;
    case (mode)
      MODE_W'(EXT_ZERO): data = w_zext;
      MODE_W'(EXT_SIGN): data = w_sext;
      MODE_W'(EXT_LUI):  data = w_lui;
      MODE_W'(EXT_BR):   data = w_br;
      MODE_W'(EXT_JMP):  data = w_jmp;
      default:           err  = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/imm_ext_stage.sv
`default_nettype none
// ============================================================================
//  Module      : imm_ext_stage
//  Description : Registered ID/EX immediate extender with valid/ready
//                handshake and a two-entry skid buffer. in_ready comes
//                straight from a flop, so no combinational path from
//                out_ready reaches the upstream stage.
//  Revision    : 1.0  initial release
// ============================================================================
module imm_ext_stage #(
  parameter int DATA_W = imm_ext_pkg::DEF_DATA_W,
  parameter int IMM_W  = imm_ext_pkg::DEF_IMM_W,
  parameter int J_W    = imm_ext_pkg::DEF_J_W,
  parameter int MODE_W = imm_ext_pkg::MODE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [J_W-1:0]    idx,
  input  logic [DATA_W-1:0] pc_plus4,
  input  logic [MODE_W-1:0] mode,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err
);
  import imm_ext_pkg::*;

  skid_state_e       state_q, state_d;
  logic [DATA_W-1:0] head_data_q, head_data_d;
  logic              head_err_q, head_err_d;
  logic [DATA_W-1:0] tail_data_q, tail_data_d;
  logic              tail_err_q, tail_err_d;
  logic              out_valid_q, out_valid_d;
  logic              in_ready_q, in_ready_d;

  logic [DATA_W-1:0] w_new_data;
  logic              w_new_err;
  logic              w_in_xfer;
  logic              w_out_xfer;

  imm_ext_core #(
    .DATA_W (DATA_W),
    .IMM_W  (IMM_W),
    .J_W    (J_W),
    .MODE_W (MODE_W)
  ) u_core (
    .idx      (idx),
    .pc_plus4 (pc_plus4),
    .mode     (mode),
    .data     (w_new_data),
    .err      (w_new_err)
  );

  assign w_in_xfer  = in_valid & in_ready_q;
  assign w_out_xfer = out_valid_q & out_ready;

  // Skid-buffer next state and storage updates; flush overrides everything.
  always_comb begin
    state_d     = state_q;
    head_data_d = head_data_q;
    head_err_d  = head_err_q;
    tail_data_d = tail_data_q;
    tail_err_d  = tail_err_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (w_in_xfer) begin
            head_data_d = w_new_data;
            head_err_d  = w_new_err;
            state_d     = ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_in_xfer && w_out_xfer) begin
            head_data_d = w_new_data;
            head_err_d  = w_new_err;
          end else if (w_in_xfer) begin
            tail_data_d = w_new_data;
            tail_err_d  = w_new_err;
            state_d     = ST_TWO;
          end else if (w_out_xfer) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          // in_ready is low here, so only the drain side can move.
          if (w_out_xfer) begin
            head_data_d = tail_data_q;
            head_err_d  = tail_err_q;
            state_d     = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    out_valid_d = (state_d != ST_EMPTY);
    in_ready_d  = (state_d != ST_TWO);
  end

  // State, storage and handshake flops; reset empties both entries at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      head_data_q <= '0;
      head_err_q  <= 1'b0;
      tail_data_q <= '0;
      tail_err_q  <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      head_data_q <= head_data_d;
      head_err_q  <= head_err_d;
      tail_data_q <= tail_data_d;
      tail_err_q  <= tail_err_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = head_data_q;
  assign out_err   = head_err_q;

endmodule
`default_nettype wire

// File: tb/tb_imm_ext_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imm_ext_stage
//  Description : Directed self-checking bench for imm_ext_stage.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_imm_ext_stage;

  localparam int DATA_W = 32;
  localparam int IMM_W  = 16;
  localparam int J_W    = 26;
  localparam int MODE_W = 3;

  logic              clk       = 1'b0;
  logic              rst_n     = 1'b0;
  logic              in_valid  = 1'b0;
  logic              flush     = 1'b0;
  logic              out_ready = 1'b1;
  logic [J_W-1:0]    idx       = '0;
  logic [DATA_W-1:0] pc_plus4  = '0;
  logic [MODE_W-1:0] mode      = '0;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_err;

  int checks = 0;
  int passed = 0;

  typedef struct packed {
    logic [J_W-1:0]    v_idx;
    logic [DATA_W-1:0] v_pc;
    logic [MODE_W-1:0] v_mode;
    logic [DATA_W-1:0] v_data;
    logic              v_err;
  } vec_t;

  localparam int N_VEC = 12;
  vec_t vecs [N_VEC] = '{
    '{26'h0008000, 32'h00000000, 3'd1, 32'hFFFF8000, 1'b0},
    '{26'h0008000, 32'h00000000, 3'd0, 32'h00008000, 1'b0},
    '{26'h0001234, 32'h00000000, 3'd2, 32'h12340000, 1'b0},
    '{26'h000FFFF, 32'h00400004, 3'd3, 32'h00400000, 1'b0},
    '{26'h0000001, 32'hFFFFFFFC, 3'd3, 32'h00000000, 1'b0},
    '{26'h0100000, 32'h90000000, 3'd4, 32'h90400000, 1'b0},
    '{26'h0001234, 32'h00000001, 3'd6, 32'h00000000, 1'b1},
    '{26'h3FFFFFF, 32'h5ABCDEF0, 3'd4, 32'h5FFFFFFC, 1'b0},
    '{26'h3FF7FFF, 32'h00000000, 3'd1, 32'h00007FFF, 1'b0},
    '{26'h3FF8001, 32'h00000000, 3'd2, 32'h80010000, 1'b0},
    '{26'h0000ABC, 32'h12345678, 3'd5, 32'h00000000, 1'b1},
    '{26'h0000ABC, 32'h12345678, 3'd7, 32'h00000000, 1'b1}
  };

  imm_ext_stage #(
    .DATA_W (DATA_W),
    .IMM_W  (IMM_W),
    .J_W    (J_W),
    .MODE_W (MODE_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .idx       (idx),
    .pc_plus4  (pc_plus4),
    .mode      (mode),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else passed++;
    checks++; if (in_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", in_ready); else passed++;
    checks++; if (out_data !== 32'h0) $display("FAIL reset_data: got %h want 00000000", out_data); else passed++;
    checks++; if (out_err !== 1'b0) $display("FAIL reset_err: got %b want 0", out_err); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL release_valid: got %b want 0", out_valid); else passed++;
    checks++; if (in_ready !== 1'b1) $display("FAIL release_ready: got %b want 1", in_ready); else passed++;
    checks++; if (out_data !== 32'h0) $display("FAIL release_data: got %h want 00000000", out_data); else passed++;
  endtask

  task automatic test_modes();
    for (int k = 0; k < N_VEC; k++) begin
      @(negedge clk);
      idx = vecs[k].v_idx; pc_plus4 = vecs[k].v_pc; mode = vecs[k].v_mode;
      in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== vecs[k].v_data)
        $display("FAIL mode_vec%0d data: valid=%b data=%h want valid=1 data=%h", k, out_valid, out_data, vecs[k].v_data);
      else passed++;
      checks++;
      if (out_err !== vecs[k].v_err)
        $display("FAIL mode_vec%0d err: got %b want %b", k, out_err, vecs[k].v_err);
      else passed++;
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) $display("FAIL mode_vec%0d drain: valid=%b want 0", k, out_valid); else passed++;
    end
  endtask

  task automatic test_throughput();
    logic [DATA_W-1:0] exp_d;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      idx = J_W'(k * 32'h11); pc_plus4 = '0; mode = 3'd0;
      in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk);
      #1;
      exp_d = k * 32'h11;
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_d || in_ready !== 1'b1)
        $display("FAIL stream%0d: valid=%b data=%h ready=%b want valid=1 data=%h ready=1", k, out_valid, out_data, in_ready, exp_d);
      else passed++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL stream_drain: valid=%b want 0", out_valid); else passed++;
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    idx = 26'h00000AA; pc_plus4 = '0; mode = 3'd0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_data !== 32'h000000AA)
      $display("FAIL b2b_first: valid=%b ready=%b data=%h want 1 1 000000AA", out_valid, in_ready, out_data);
    else passed++;
    @(negedge clk);
    idx = 26'h00000BB; mode = 3'd2;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_data !== 32'h000000AA)
      $display("FAIL b2b_full: ready=%b data=%h want 0 000000AA", in_ready, out_data);
    else passed++;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== 32'h000000AA || out_err !== 1'b0)
        $display("FAIL b2b_hold%0d: valid=%b ready=%b data=%h err=%b want 1 0 000000AA 0", k, out_valid, in_ready, out_data, out_err);
      else passed++;
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_data !== 32'h00BB0000)
      $display("FAIL b2b_second: valid=%b ready=%b data=%h want 1 1 00BB0000", out_valid, in_ready, out_data);
    else passed++;
    @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL b2b_empty: valid=%b want 0", out_valid); else passed++;
  endtask

  task automatic test_flush();
    // Fill both entries, then flush with a new request alongside.
    @(negedge clk);
    idx = 26'h0000011; pc_plus4 = '0; mode = 3'd0; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    idx = 26'h0000022;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) $display("FAIL flush_pre_two: ready=%b want 0", in_ready); else passed++;
    idx = 26'h0000033; flush = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL flush_two: valid=%b ready=%b want 0 1", out_valid, in_ready);
    else passed++;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      checks++; if (out_valid !== 1'b0) $display("FAIL flush_quiet%0d: valid=%b want 0", k, out_valid); else passed++;
    end
    // Flush in ONE while in_ready is high: the incoming request is dropped too.
    @(negedge clk);
    idx = 26'h0000044; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    idx = 26'h0000055; flush = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL flush_one: valid=%b ready=%b want 0 1", out_valid, in_ready);
    else passed++;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL flush_one_quiet: valid=%b want 0", out_valid); else passed++;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    idx = 26'h000FFFF; pc_plus4 = '0; mode = 3'd1; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hFFFFFFFF)
      $display("FAIL arst_pre: valid=%b data=%h want 1 FFFFFFFF", out_valid, out_data);
    else passed++;
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'h0)
      $display("FAIL arst_now: valid=%b ready=%b data=%h want 0 1 00000000", out_valid, in_ready, out_data);
    else passed++;
    #4;
    rst_n = 1'b1;
    @(negedge clk);
    idx = 26'h00000AB; mode = 3'd2; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h00AB0000 || out_err !== 1'b0)
      $display("FAIL arst_after: valid=%b data=%h err=%b want 1 00AB0000 0", out_valid, out_data, out_err);
    else passed++;
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL arst_drain: valid=%b want 0", out_valid); else passed++;
  endtask

  initial begin
    test_reset();
    test_modes();
    test_throughput();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
